// File: rtl/mul_seq_unit_pkg.sv
// Shared constants for the sequential shift-add multiplier.
package mul_seq_unit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    // The step counter must reach WIDTH-1 without wrapping.
    function automatic int unsigned cntWidth(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_seq_unit_if.sv
// Request/response bundle between the ALU and the sequential multiplier.
interface mul_seq_unit_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic               iStart;
    logic [WIDTH-1:0]   iA;
    logic [WIDTH-1:0]   iB;
    logic               oBusy;
    logic               oDone;
    logic [2*WIDTH-1:0] oProduct;
    logic               oOverflow;

    modport master (
        output iStart, iA, iB,
        input  oBusy, oDone, oProduct, oOverflow
    );

    modport slave (
        input  iStart, iA, iB,
        output oBusy, oDone, oProduct, oOverflow
    );

endinterface

// File: rtl/mul_seq_unit_dff.sv
// Generic synchronous-reset D flip-flop with load enable.
module mul_seq_unit_dff #(
    parameter int unsigned Width = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iEn,
    input  logic [Width-1:0] iD,
    output logic [Width-1:0] oQ
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oQ <= '0;
        end else if (iEn) begin
            oQ <= iD;
        end
    end

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential unsigned shift-add multiplier: one partial product per clock,
// WIDTH-cycle fixed latency, registered product and overflow flag.
module mul_seq_unit
    import mul_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          Clock,
    input  logic          Reset,
    mul_seq_unit_if.slave bus
);

    localparam int unsigned CW = cntWidth(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT              state, stateNext;
    logic [2*WIDTH-1:0] aReg;
    logic [WIDTH-1:0]   bReg;
    logic [2*WIDTH-1:0] accReg;
    logic [2*WIDTH-1:0] accNext;
    logic [CW-1:0]      cnt;
    logic               accept;
    logic               finish;
    logic [2*WIDTH:0]   outQ;

    // Next accumulator includes the current step so the final sum can be
    // captured on the same edge that enters DONE.
    assign accNext = accReg + (bReg[0] ? aReg : '0);
    assign finish  = (state == RUN) && (cnt == LAST);

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (bus.iStart) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            aReg   <= '0;
            bReg   <= '0;
            accReg <= '0;
            cnt    <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                aReg   <= {{WIDTH{1'b0}}, bus.iA};
                bReg   <= bus.iB;
                accReg <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                accReg <= accNext;
                aReg   <= aReg << 1;
                bReg   <= bReg >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    mul_seq_unit_dff #(
        .Width(2 * WIDTH + 1)
    ) uOutReg (
        .Clock(Clock),
        .Reset(Reset),
        .iEn  (finish),
        .iD   ({|accNext[2*WIDTH-1:WIDTH], accNext}),
        .oQ   (outQ)
    );

    assign bus.oBusy     = (state == RUN);
    assign bus.oDone     = (state == DONE);
    assign bus.oProduct  = outQ[2*WIDTH-1:0];
    assign bus.oOverflow = outQ[2*WIDTH];

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit against an arithmetic reference model.
module tb_mul_seq_unit;

    localparam int unsigned W = 16;

    logic Clock;
    logic Reset;
    int   checks;
    int   passed;

    mul_seq_unit_if #(.WIDTH(W)) bus ();

    mul_seq_unit #(
        .WIDTH(W)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Reference model: plain full-width arithmetic.
    function automatic logic [63:0] refProd(input logic [W-1:0] a, input logic [W-1:0] b);
        return 64'(a) * 64'(b);
    endfunction

    function automatic logic refOvf(input logic [W-1:0] a, input logic [W-1:0] b);
        return (refProd(a, b) >> W) != 64'd0;
    endfunction

    // Drive a one-cycle start; returns at the falling edge after acceptance.
    task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clock);
        bus.iStart = 1'b1;
        bus.iA     = a;
        bus.iB     = b;
        @(negedge Clock);
        bus.iStart = 1'b0;
    endtask

    task automatic waitDone(output int lat, output int busyCnt);
        lat     = 0;
        busyCnt = 0;
        while (!bus.oDone && lat < 40) begin
            if (bus.oBusy) busyCnt++;
            @(negedge Clock);
            lat++;
        end
    endtask

    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, busyCnt;
        startOp(a, b);
        waitDone(lat, busyCnt);
        check({tag, " latency"}, 64'(lat), 64'(W));
        check({tag, " busy"}, 64'(busyCnt), 64'(W));
        check({tag, " busyAtDone"}, 64'(bus.oBusy), 64'd0);
        check({tag, " product"}, 64'(bus.oProduct), refProd(a, b));
        check({tag, " overflow"}, 64'(bus.oOverflow), 64'(refOvf(a, b)));
        @(negedge Clock);
        check({tag, " donePulse"}, 64'(bus.oDone), 64'd0);
    endtask

    initial begin
        int lat, busyCnt, doneCnt, changed;
        logic [2*W-1:0] held;
        logic [W-1:0] ra, rb;

        checks     = 0;
        passed     = 0;
        Reset      = 1'b1;
        bus.iStart = 1'b0;
        bus.iA     = '0;
        bus.iB     = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        check("reset busy", 64'(bus.oBusy), 64'd0);
        check("reset done", 64'(bus.oDone), 64'd0);
        check("reset product", 64'(bus.oProduct), 64'd0);
        check("reset overflow", 64'(bus.oOverflow), 64'd0);

        runOp("3x5", 16'd3, 16'd5);
        check("3x5 literal", 64'(bus.oProduct), 64'h0000000F);
        runOp("max", 16'hFFFF, 16'hFFFF);
        check("max literal", 64'(bus.oProduct), 64'hFFFE0001);
        runOp("zero", 16'd0, 16'h1234);

        // Result must hold with no further start.
        held    = bus.oProduct;
        changed = 0;
        doneCnt = 0;
        repeat (50) begin
            @(negedge Clock);
            if (bus.oProduct !== held) changed++;
            if (bus.oDone) doneCnt++;
        end
        check("hold changes", 64'(changed), 64'd0);
        check("hold dones", 64'(doneCnt), 64'd0);

        // Start while busy is ignored.
        startOp(16'd7, 16'd9);
        lat = 0;
        while (!bus.oDone && lat < 40) begin
            if (lat == 5) begin
                bus.iStart = 1'b1;
                bus.iA     = 16'd2;
                bus.iB     = 16'd2;
            end else begin
                bus.iStart = 1'b0;
            end
            @(negedge Clock);
            lat++;
        end
        bus.iStart = 1'b0;
        check("busyStart latency", 64'(lat), 64'(W));
        check("busyStart product", 64'(bus.oProduct), 64'd63);
        doneCnt = 0;
        repeat (30) begin
            @(negedge Clock);
            if (bus.oDone) doneCnt++;
        end
        check("busyStart extra dones", 64'(doneCnt), 64'd0);

        // Back-to-back: second start issued in the DONE cycle.
        startOp(16'h0100, 16'h0100);
        waitDone(lat, busyCnt);
        check("b2b first product", 64'(bus.oProduct), 64'h00010000);
        check("b2b first overflow", 64'(bus.oOverflow), 64'd1);
        bus.iStart = 1'b1;
        bus.iA     = 16'd6;
        bus.iB     = 16'd7;
        @(negedge Clock);
        bus.iStart = 1'b0;
        check("b2b busy no gap", 64'(bus.oBusy), 64'd1);
        waitDone(lat, busyCnt);
        check("b2b spacing", 64'(lat + 1), 64'(W + 1));
        check("b2b second product", 64'(bus.oProduct), 64'd42);
        check("b2b second overflow", 64'(bus.oOverflow), 64'd0);

        // Reset in the middle of RUN aborts.
        startOp(16'd10, 16'd10);
        repeat (8) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset   = 1'b0;
        doneCnt = 0;
        changed = 0;
        repeat (30) begin
            if (bus.oDone) doneCnt++;
            if (bus.oBusy || bus.oProduct != '0 || bus.oOverflow) changed++;
            @(negedge Clock);
        end
        check("abort dones", 64'(doneCnt), 64'd0);
        check("abort outputs nonzero", 64'(changed), 64'd0);
        runOp("after abort 4x4", 16'd4, 16'd4);

        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i == 0) rb = W'($urandom_range(255, 1));
            runOp($sformatf("rand%0d", i), ra, rb);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
